// File: rtl/ysyx_23060332_dmem_resp_pkg.sv
// ysyx_23060332_dmem_resp_pkg: shared widths, enables, FSM states and byte-merge helper for the data-memory responder
package ysyx_23060332_dmem_resp_pkg;

    localparam int MemAddrBus = 32;
    localparam int MemDataBus = 32;
    localparam logic ReadEnable  = 1'b1;
    localparam logic WriteEnable = 1'b1;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_e;

    // Overlay the enabled byte lanes of new_w onto old_w.
    function automatic logic [MemDataBus-1:0] byte_merge(input logic [MemDataBus-1:0] old_w,
                                                         input logic [MemDataBus-1:0] new_w,
                                                         input logic [3:0] be);
        logic [MemDataBus-1:0] r;
        for (int i = 0; i < 4; i++) r[8*i+:8] = be[i] ? new_w[8*i+:8] : old_w[8*i+:8];
        return r;
    endfunction

endpackage

// File: rtl/ysyx_23060332_dmem_ram.sv
// ysyx_23060332_dmem_ram: word RAM with per-byte write enables and asynchronous read
module ysyx_23060332_dmem_ram import ysyx_23060332_dmem_resp_pkg::*; #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IW = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk,
    input  logic [3:0]            we,
    input  logic [IW-1:0]         waddr,
    input  logic [MemDataBus-1:0] wdata,
    input  logic [IW-1:0]         raddr,
    output logic [MemDataBus-1:0] rdata
);

    logic [MemDataBus-1:0] mem_q [DEPTH_WORDS];

    // Contents are deliberately not reset so they survive a controller reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) if (we[b]) mem_q[waddr][8*b+:8] <= wdata[8*b+:8];
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/ysyx_23060332_dmem_resp.sv
// ysyx_23060332_dmem_resp: latency-programmable load/store responder in front of the data RAM
module ysyx_23060332_dmem_resp import ysyx_23060332_dmem_resp_pkg::*; #(
    parameter logic [MemAddrBus-1:0] ADDR_BASE = 32'h8000_0000,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_ren,
    input  logic [MemAddrBus-1:0] mem_raddr,
    input  logic                  mem_wen,
    input  logic [MemAddrBus-1:0] mem_waddr,
    input  logic [MemDataBus-1:0] mem_wdata,
    input  logic [7:0]            mem_wmask,
    output logic                  mem_ready,
    output logic                  mem_ack,
    output logic [MemDataBus-1:0] mem_rdata,
    output logic                  mem_err
);

    localparam int IW = $clog2(DEPTH_WORDS);
    localparam logic [MemAddrBus-1:0] SPAN = MemAddrBus'(DEPTH_WORDS) << 2;

    dmem_state_e           state_q;
    logic [3:0]            cnt_q;
    logic [IW-1:0]         ridx_q;
    logic                  rok_q, perr_q, ack_q, err_q;
    logic [MemDataBus-1:0] rdata_q;

    logic [MemAddrBus-1:0] rdiff, wdiff;
    logic [IW-1:0]         ridx_in, widx, rd_idx;
    logic                  idle, accept, rerr, werr, wr_ok, rok_now, perr_now;
    logic [MemDataBus-1:0] ram_rdata, word_d, rdata_d;
    logic                  err_d;
    logic                  unused_wmask_hi;

    assign unused_wmask_hi = ^mem_wmask[7:4];

    assign rdiff   = mem_raddr - ADDR_BASE;
    assign wdiff   = mem_waddr - ADDR_BASE;
    assign ridx_in = rdiff[IW+1:2];
    assign widx    = wdiff[IW+1:2];
    assign rerr    = (mem_raddr < ADDR_BASE) | (rdiff >= SPAN) | (mem_raddr[1:0] != 2'b00);
    assign werr    = (mem_waddr < ADDR_BASE) | (wdiff >= SPAN) | (mem_waddr[1:0] != 2'b00);

    assign idle     = state_q == DMEM_IDLE;
    assign accept   = idle & ((mem_ren == ReadEnable) | (mem_wen == WriteEnable));
    assign wr_ok    = accept & mem_wen & ~werr;
    assign rok_now  = mem_ren & ~rerr;
    assign perr_now = (mem_ren & rerr) | (mem_wen & werr);
    assign rd_idx   = idle ? ridx_in : ridx_q;

    ysyx_23060332_dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS), .IW(IW)) u_ram (
        .clk   (clk),
        .we    ({4{wr_ok}} & mem_wmask[3:0]),
        .waddr (widx),
        .wdata (mem_wdata),
        .raddr (rd_idx),
        .rdata (ram_rdata)
    );

    // A direct IDLE->RESP hop reads on the same edge as the write, so forward the new bytes.
    always_comb begin
        word_d  = (idle & wr_ok & (widx == ridx_in)) ? byte_merge(ram_rdata, mem_wdata, mem_wmask[3:0]) : ram_rdata;
        rdata_d = (idle ? rok_now : rok_q) ? word_d : '0;
        err_d   = idle ? perr_now : perr_q;
    end

    // Request FSM with registered response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DMEM_IDLE;
            cnt_q   <= '0;
            ridx_q  <= '0;
            rok_q   <= 1'b0;
            perr_q  <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            case (state_q)
                DMEM_IDLE: if (accept) begin
                    ridx_q <= ridx_in;
                    rok_q  <= rok_now;
                    perr_q <= perr_now;
                    if (LATENCY == 1) begin
                        state_q <= DMEM_RESP;
                        ack_q   <= 1'b1;
                        rdata_q <= rdata_d;
                        err_q   <= err_d;
                    end else begin
                        state_q <= DMEM_WAIT;
                        cnt_q   <= 4'(LATENCY - 1);
                    end
                end
                DMEM_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= DMEM_RESP;
                        ack_q   <= 1'b1;
                        rdata_q <= rdata_d;
                        err_q   <= err_d;
                    end
                end
                default: state_q <= DMEM_IDLE;
            endcase
        end
    end

    assign mem_ready = idle;
    assign mem_ack   = ack_q;
    assign mem_rdata = rdata_q;
    assign mem_err   = err_q;

endmodule

// File: tb/tb_ysyx_23060332_dmem_resp.sv
// tb_ysyx_23060332_dmem_resp: directed checks of the responder at LATENCY=1 (d=0) and LATENCY=4 (d=1)
module tb_ysyx_23060332_dmem_resp;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0]       ren = '0, wen = '0, ready, ack, err;
    logic [1:0][31:0] raddr = '0, waddr = '0, wdata = '0, rdata;
    logic [1:0][7:0]  wmask = '0;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ysyx_23060332_dmem_resp #(.LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .mem_ren(ren[0]), .mem_raddr(raddr[0]), .mem_wen(wen[0]),
        .mem_waddr(waddr[0]), .mem_wdata(wdata[0]), .mem_wmask(wmask[0]),
        .mem_ready(ready[0]), .mem_ack(ack[0]), .mem_rdata(rdata[0]), .mem_err(err[0])
    );

    ysyx_23060332_dmem_resp #(.LATENCY(4)) dut4 (
        .clk(clk), .rst(rst), .mem_ren(ren[1]), .mem_raddr(raddr[1]), .mem_wen(wen[1]),
        .mem_waddr(waddr[1]), .mem_wdata(wdata[1]), .mem_wmask(wmask[1]),
        .mem_ready(ready[1]), .mem_ack(ack[1]), .mem_rdata(rdata[1]), .mem_err(err[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs(input int d);
        ren[d] = 1'b0; wen[d] = 1'b0; raddr[d] = '0; waddr[d] = '0; wdata[d] = '0; wmask[d] = '0;
    endtask

    // One transaction: wait for ready, present for one cycle, wait for ack.
    task automatic xact(input int d, input logic r, input logic w, input logic [31:0] ra,
                        input logic [31:0] wa, input logic [31:0] wd, input logic [7:0] m,
                        output logic [31:0] rd, output logic e, output int lat, output logic rdy);
        int guard = 0;
        while (!ready[d] && guard < 20) begin cyc(); guard++; end
        ren[d] = r; wen[d] = w; raddr[d] = ra; waddr[d] = wa; wdata[d] = wd; wmask[d] = m;
        lat = 0;
        do begin
            cyc();
            idle_inputs(d);
            lat++;
        end while (!ack[d] && lat < 20);
        check("ack_seen", {31'b0, ack[d]}, 32'd1);
        rd = rdata[d]; e = err[d]; rdy = ready[d];
    endtask

    logic [31:0] rd;
    logic e, rdy;
    int lat, acks;

    initial begin
        repeat (3) cyc();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("idle_ctl", {29'b0, ready[0], ack[0], err[0]}, 32'b100);
            check("idle_rdata", rdata[0], 32'h0);
        end
        check("idle_ctl4", {29'b0, ready[1], ack[1], err[1]}, 32'b100);

        xact(0, 0, 1, 0, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, rd, e, lat, rdy);
        check("wr_lat", lat, 1);
        check("wr_err", {31'b0, e}, 0);
        check("wr_rdata", rd, 0);

        xact(0, 1, 0, 32'h8000_0010, 0, 0, 0, rd, e, lat, rdy);
        check("rd_lat", lat, 1);
        check("rd_data", rd, 32'hDEAD_BEEF);
        check("rd_ready_low", {31'b0, rdy}, 0);
        cyc();
        check("ack_one_cycle", {31'b0, ack[0]}, 0);

        xact(0, 0, 1, 0, 32'h8000_0010, 32'h1122_3344, 8'hF5, rd, e, lat, rdy);
        xact(0, 1, 0, 32'h8000_0010, 0, 0, 0, rd, e, lat, rdy);
        check("mask_rd", rd, 32'hDE22_BE44);

        xact(0, 0, 1, 0, 32'h8000_0010, 32'hFFFF_FFFF, 8'hF0, rd, e, lat, rdy);
        check("nomask_err", {31'b0, e}, 0);
        xact(0, 1, 0, 32'h8000_0010, 0, 0, 0, rd, e, lat, rdy);
        check("nomask_rd", rd, 32'hDE22_BE44);

        xact(0, 1, 0, 32'h7FFF_FFFC, 0, 0, 0, rd, e, lat, rdy);
        check("low_err", {31'b0, e}, 1);
        check("low_rdata", rd, 0);

        xact(0, 0, 1, 0, 32'h8000_0012, 32'h0000_0000, 8'h0F, rd, e, lat, rdy);
        check("misal_err", {31'b0, e}, 1);
        xact(0, 1, 0, 32'h8000_0010, 0, 0, 0, rd, e, lat, rdy);
        check("misal_keep", rd, 32'hDE22_BE44);
        check("misal_rb_err", {31'b0, e}, 0);

        xact(0, 1, 0, 32'h8000_1000, 0, 0, 0, rd, e, lat, rdy);
        check("high_err", {31'b0, e}, 1);
        check("high_rdata", rd, 0);

        xact(0, 1, 1, 32'h8000_0FFC, 32'h8000_0FFC, 32'h0BAD_F00D, 8'h0F, rd, e, lat, rdy);
        check("last_word_err", {31'b0, e}, 0);
        check("last_word_fwd", rd, 32'h0BAD_F00D);

        ren[1] = 1'b1; wen[1] = 1'b1; raddr[1] = 32'h8000_0020; waddr[1] = 32'h8000_0020;
        wdata[1] = 32'hCAFE_F00D; wmask[1] = 8'h0F;
        lat = 0;
        do begin
            cyc();
            lat++;
            ren[1] = 1'b0; wen[1] = 1'b1; wdata[1] = 32'h0; wmask[1] = 8'h0F;
        end while (!ack[1] && lat < 20);
        check("l4_lat", lat, 4);
        check("l4_rdata", rdata[1], 32'hCAFE_F00D);
        check("l4_err", {31'b0, err[1]}, 0);
        cyc();
        idle_inputs(1);
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            acks += int'(ack[1]);
        end
        check("l4_no_extra_ack", acks, 0);
        xact(1, 1, 0, 32'h8000_0020, 0, 0, 0, rd, e, lat, rdy);
        check("l4_ram_kept", rd, 32'hCAFE_F00D);

        while (!ready[1]) cyc();
        wen[1] = 1'b1; waddr[1] = 32'h8000_0030; wdata[1] = 32'h1234_5678; wmask[1] = 8'h0F;
        cyc();
        idle_inputs(1);
        check("wait_ready_low", {31'b0, ready[1]}, 0);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            acks += int'(ack[1]);
            check("rst_ready", {31'b0, ready[1]}, 1);
        end
        check("rst_no_ack", acks, 0);
        xact(1, 1, 0, 32'h8000_0030, 0, 0, 0, rd, e, lat, rdy);
        check("rst_keep_wr", rd, 32'h1234_5678);
        xact(0, 1, 0, 32'h8000_0010, 0, 0, 0, rd, e, lat, rdy);
        check("rst_keep_ram", rd, 32'hDE22_BE44);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
